// File: rtl/arm7tdmi_mem_responder.sv
// Word-organised RAM responder for the ARM7TDMI data bus, with a registered
// mem_ready pulse after WAIT_STATES wait cycles. Optional data abort: MEM_RESP_ABORT_EN.
module arm7tdmi_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_we,
  input  logic        mem_re,
  input  logic [3:0]  mem_be,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_abort
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic        ready_q, ready_d;
  logic        abort_q, abort_d;
  logic [31:0] rdata_q, rdata_d;

  logic          commit;
  logic          ram_we;
  logic [AW-1:0] idx;

  logic [31:0] ram [DEPTH_WORDS];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    abort_d = 1'b0;
    commit  = 1'b0;
    ram_we  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (mem_re || mem_we) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          be_d    = mem_be;
          we_d    = mem_we;
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // ADDR_BASE is aligned to the RAM span, so the subtraction only matters above idx.
    idx = addr_d[AW+1:2] - ADDR_BASE[AW+1:2];

    if (commit) begin
      ready_d = 1'b1;
`ifdef MEM_RESP_ABORT_EN
      if ((addr_d - ADDR_BASE) >= 32'(4 * DEPTH_WORDS)) begin
        abort_d = 1'b1;
        if (!we_d) rdata_d = 32'h0;
      end else begin
        ram_we = we_d && rst_n;
        if (!we_d) rdata_d = ram[idx];
      end
`else
      ram_we = we_d && rst_n;
      if (!we_d) rdata_d = ram[idx];
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; all next values come from always_comb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      abort_q <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      ready_q <= ready_d;
      abort_q <= abort_d;
      rdata_q <= rdata_d;
    end
  end

  // NOTE: the RAM array has no reset so it maps onto block RAM with byte enables.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be_d[i]) ram[idx][8*i +: 8] <= wdata_d[8*i +: 8];
      end
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = ready_q;
  assign mem_abort = abort_q;

endmodule

// File: tb/tb_arm7tdmi_mem_responder.sv
// Directed bench for arm7tdmi_mem_responder: three instances (0 and 3 wait states,
// plus a 256-word instance for the out-of-range / abort case) sharing one address bus.
module tb_arm7tdmi_mem_responder;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [2:0]  we_v;
  logic [2:0]  re_v;
  logic [2:0]  ready_v;
  logic [2:0]  abort_v;
  logic [31:0] rdata_v [3];

  int n_cmp = 0;
  int n_err = 0;

  arm7tdmi_mem_responder #(.DEPTH_WORDS(2048), .WAIT_STATES(0), .ADDR_BASE(32'h0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .mem_addr(addr), .mem_wdata(wdata), .mem_we(we_v[0]),
    .mem_re(re_v[0]), .mem_be(be), .mem_rdata(rdata_v[0]), .mem_ready(ready_v[0]),
    .mem_abort(abort_v[0]));

  arm7tdmi_mem_responder #(.DEPTH_WORDS(2048), .WAIT_STATES(3), .ADDR_BASE(32'h0)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .mem_addr(addr), .mem_wdata(wdata), .mem_we(we_v[1]),
    .mem_re(re_v[1]), .mem_be(be), .mem_rdata(rdata_v[1]), .mem_ready(ready_v[1]),
    .mem_abort(abort_v[1]));

  arm7tdmi_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0), .ADDR_BASE(32'h0)) u_dut_small (
    .clk(clk), .rst_n(rst_n), .mem_addr(addr), .mem_wdata(wdata), .mem_we(we_v[2]),
    .mem_re(re_v[2]), .mem_be(be), .mem_rdata(rdata_v[2]), .mem_ready(ready_v[2]),
    .mem_abort(abort_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request to instance d; hold it for 'hold' extra cycles, then drop it and
  // move the address bus to late_addr. lat counts cycles from acceptance to mem_ready.
  task automatic access(input int d, input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] b, input int hold,
                        input logic [31:0] late_addr, output int lat,
                        output logic [31:0] rd, output logic ab);
    bit got;
    @(negedge clk);
    addr = a; wdata = wd; be = b; we_v[d] = w; re_v[d] = r;
    lat = 0; got = 0;
    while (lat < 40 && !got) begin
      @(negedge clk);
      lat++;
      if (lat > hold) begin
        we_v[d] = 1'b0; re_v[d] = 1'b0; addr = late_addr;
      end
      if (ready_v[d]) got = 1;
    end
    rd = rdata_v[d];
    ab = abort_v[d];
  endtask

  // Request held high across RESP; the second pulse is where the bench finally drops it.
  task automatic back_to_back(input int d, input int exp_first, input int exp_gap, input string tag);
    int n, p1, p2, dbl;
    logic prev;
    n = 0; p1 = 0; p2 = 0; dbl = 0; prev = 1'b0;
    @(negedge clk);
    addr = 32'h1000; re_v[d] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ready_v[d]) begin
        n++;
        if (prev) dbl++;
        if (n == 1) p1 = i;
        if (n == 2) begin p2 = i; re_v[d] = 1'b0; end
      end
      prev = ready_v[d];
    end
    re_v[d] = 1'b0;
    check({tag, "_first"}, 32'(p1), 32'(exp_first));
    check({tag, "_gap"},   32'(p2 - p1), 32'(exp_gap));
    check({tag, "_pulses"}, 32'(n), 32'd2);
    check({tag, "_double"}, 32'(dbl), 32'd0);
  endtask

  initial begin
    int          lat, cnt;
    logic [31:0] rd;
    logic        ab;
    logic [31:0] exp_w0, exp_oor, exp_ab;

    rst_n = 1'b0; addr = '0; wdata = '0; be = '0; we_v = '0; re_v = '0;
    #1;
    check("reset_ready", 32'(ready_v), 32'h0);
    check("reset_abort", 32'(abort_v), 32'h0);
    check("reset_rdata0", rdata_v[0], 32'h0);
    check("reset_rdata3", rdata_v[1], 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Zero wait states: write then read back
    access(0, 1, 0, 32'h1000, 32'h1234_5678, 4'hF, 0, 32'h1000, lat, rd, ab);
    check("ws0_wr_lat", 32'(lat), 32'd1);
    access(0, 0, 1, 32'h1000, 32'h0, 4'hF, 0, 32'h1000, lat, rd, ab);
    check("ws0_rd_lat", 32'(lat), 32'd1);
    check("ws0_rd_data", rd, 32'h1234_5678);
    check("ws0_rd_abort", 32'(ab), 32'd0);

    // Byte lanes
    access(0, 1, 0, 32'h1010, 32'h0, 4'hF, 0, 32'h1010, lat, rd, ab);
    access(0, 1, 0, 32'h1010, 32'h0000_AB00, 4'b0010, 0, 32'h1010, lat, rd, ab);
    access(0, 0, 1, 32'h1010, 32'h0, 4'h0, 0, 32'h1010, lat, rd, ab);
    check("lane1_only", rd, 32'h0000_AB00);
    access(0, 1, 0, 32'h1012, 32'h1122_3344, 4'b1001, 0, 32'h1012, lat, rd, ab);
    access(0, 0, 1, 32'h1013, 32'h0, 4'h1, 0, 32'h1013, lat, rd, ab);
    check("lanes_0_3", rd, 32'h1100_AB44);

    // Both we and re: write only, rdata holds the last read value
    access(0, 1, 1, 32'h1000, 32'h5555_5555, 4'hF, 0, 32'h1000, lat, rd, ab);
    check("we_re_hold", rd, 32'h1100_AB44);
    access(0, 0, 1, 32'h1000, 32'h0, 4'hF, 0, 32'h1000, lat, rd, ab);
    check("we_re_wrote", rd, 32'h5555_5555);

    // Three wait states; inputs dropped and address moved two cycles after acceptance
    access(1, 1, 0, 32'h1000, 32'hA5A5_A5A5, 4'hF, 0, 32'h1000, lat, rd, ab);
    check("ws3_wr_lat", 32'(lat), 32'd4);
    access(1, 1, 0, 32'h1008, 32'h0BAD_F00D, 4'hF, 0, 32'h1008, lat, rd, ab);
    access(1, 0, 1, 32'h1000, 32'h0, 4'hF, 1, 32'h1008, lat, rd, ab);
    check("ws3_rd_lat", 32'(lat), 32'd4);
    check("ws3_rd_latched", rd, 32'hA5A5_A5A5);

    // Reset during WAIT of a write
    access(1, 1, 0, 32'h1004, 32'hCAFE_F00D, 4'hF, 0, 32'h1004, lat, rd, ab);
    access(1, 0, 1, 32'h1004, 32'h0, 4'hF, 0, 32'h1004, lat, rd, ab);
    check("pre_rst_read", rd, 32'hCAFE_F00D);
    @(negedge clk);
    addr = 32'h1004; wdata = 32'hDEAD_BEEF; be = 4'hF; we_v[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    we_v[1] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_ready", 32'(ready_v[1]), 32'd0);
    check("rst_mid_rdata", rdata_v[1], 32'h0);
    check("rst_mid_rdata0", rdata_v[0], 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ready_v[1]) cnt++;
    end
    check("rst_no_ready", 32'(cnt), 32'd0);
    access(1, 0, 1, 32'h1004, 32'h0, 4'hF, 0, 32'h1004, lat, rd, ab);
    check("rst_old_value", rd, 32'hCAFE_F00D);

    // Back-to-back with request held across RESP
    back_to_back(1, 4, 5, "b2b_ws3");
    back_to_back(0, 1, 2, "b2b_ws0");

    // Out-of-range write on the 256-word instance
`ifdef MEM_RESP_ABORT_EN
    exp_w0 = 32'h1111_2222; exp_oor = 32'h0; exp_ab = 32'd1;
`else
    exp_w0 = 32'h9999_9999; exp_oor = 32'h9999_9999; exp_ab = 32'd0;
`endif
    access(2, 1, 0, 32'h0, 32'h1111_2222, 4'hF, 0, 32'h0, lat, rd, ab);
    check("small_wr_abort", 32'(ab), 32'd0);
    access(2, 1, 0, 32'h400, 32'h9999_9999, 4'hF, 0, 32'h400, lat, rd, ab);
    check("oor_wr_lat", 32'(lat), 32'd1);
    check("oor_wr_abort", 32'(ab), exp_ab);
    access(2, 0, 1, 32'h0, 32'h0, 4'hF, 0, 32'h0, lat, rd, ab);
    check("oor_word0", rd, exp_w0);
    check("oor_word0_abort", 32'(ab), 32'd0);
    access(2, 0, 1, 32'h400, 32'h0, 4'hF, 0, 32'h400, lat, rd, ab);
    check("oor_rd_data", rd, exp_oor);
    check("oor_rd_abort", 32'(ab), exp_ab);
    @(negedge clk);
    check("abort_idle", 32'(abort_v[2]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
